// File: rtl/kernel_launch_ctrl.sv
// kernel_launch_ctrl: soft-resets a kernel, starts it, then polls
// its done word over OBI until it reads 1 or a timeout expires.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   launch_i          launch request pulse (ignored while busy)
//   busy_o            sequence in progress
//   done_o            one-cycle completion pulse
//   timeout_o         sticky timeout flag, cleared on launch
//   cycles_o          kernel cycles from start grant to last poll
//   conf_*            OBI master for the reset/start conf writes
//   mem_*             OBI master for the done-word reads
module kernel_launch_ctrl #(
  parameter logic [31:0] RST_REG_ADDR   = 32'h0,
  parameter logic [31:0] START_REG_ADDR = 32'h4,
  parameter logic [31:0] DONE_ADDR      = 32'h0002_7C00,
  parameter int unsigned SETTLE_CYCLES  = 50,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        launch_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cycles_o,
  output logic        conf_req_o,
  input  logic        conf_gnt_i,
  output logic        conf_we_o,
  output logic [3:0]  conf_be_o,
  output logic [31:0] conf_addr_o,
  output logic [31:0] conf_wdata_o,
  input  logic        conf_rvalid_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] SETTLE_LIM = 32'(SETTLE_CYCLES);
  localparam logic [31:0] POLL_LIM   = 32'(POLL_INTERVAL);

  typedef enum logic [3:0] {
    IDLE,
    RST_REQ,
    RST_RSP,
    SETTLE,
    START_REQ,
    START_RSP,
    POLL_WAIT,
    POLL_REQ,
    POLL_RSP,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] wait_cnt;
  logic [31:0] cycles;
  logic        timeout_q;

  logic        clr_run;
  logic        cyc_clr;
  logic        cyc_run;
  logic        set_to;
  logic        cnt_run;
  logic        settle_done;
  logic        poll_done;
  logic        timed_out;

  // A limit of 0 still spends one cycle in the wait state.
  assign settle_done = (wait_cnt + 32'd1) >= SETTLE_LIM;
  assign poll_done   = (wait_cnt + 32'd1) >= POLL_LIM;
  assign timed_out   = cycles >= TIMEOUT_CYCLES;

  assign cyc_run = state inside {START_RSP, POLL_WAIT,
                                 POLL_REQ, POLL_RSP};

  assign busy_o    = state != IDLE;
  assign done_o    = state == FINISH;
  assign timeout_o = timeout_q;
  assign cycles_o  = cycles;
  assign mem_we_o  = 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cycles    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_run ? wait_cnt + 32'd1 : '0;
      if (clr_run || cyc_clr) begin
        cycles <= '0;
      end else if (cyc_run && cycles != '1) begin
        cycles <= cycles + 32'd1;
      end
      if (clr_run) begin
        timeout_q <= 1'b0;
      end else if (set_to) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    clr_run      = 1'b0;
    cyc_clr      = 1'b0;
    set_to       = 1'b0;
    cnt_run      = 1'b0;
    conf_req_o   = 1'b0;
    conf_we_o    = 1'b0;
    conf_be_o    = 4'h0;
    conf_addr_o  = '0;
    conf_wdata_o = '0;
    mem_req_o    = 1'b0;
    mem_be_o     = 4'h0;
    mem_addr_o   = '0;
    unique case (state)
      IDLE: begin
        if (launch_i) begin
          state_n = RST_REQ;
          clr_run = 1'b1;
        end
      end
      RST_REQ: begin
        conf_req_o   = 1'b1;
        conf_we_o    = 1'b1;
        conf_be_o    = 4'hF;
        conf_addr_o  = RST_REG_ADDR;
        conf_wdata_o = 32'd1;
        if (conf_gnt_i) state_n = RST_RSP;
      end
      RST_RSP: begin
        if (conf_rvalid_i) state_n = SETTLE;
      end
      SETTLE: begin
        if (settle_done) state_n = START_REQ;
        else cnt_run = 1'b1;
      end
      START_REQ: begin
        conf_req_o   = 1'b1;
        conf_we_o    = 1'b1;
        conf_be_o    = 4'hF;
        conf_addr_o  = START_REG_ADDR;
        conf_wdata_o = 32'd1;
        if (conf_gnt_i) begin
          state_n = START_RSP;
          cyc_clr = 1'b1;
        end
      end
      START_RSP: begin
        if (conf_rvalid_i) state_n = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (timed_out) begin
          state_n = FINISH;
          set_to  = 1'b1;
        end else if (poll_done) begin
          state_n = POLL_REQ;
        end else begin
          cnt_run = 1'b1;
        end
      end
      POLL_REQ: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = DONE_ADDR;
        if (mem_gnt_i) state_n = POLL_RSP;
      end
      POLL_RSP: begin
        // A read already in flight completes before timing out.
        if (mem_rvalid_i) begin
          if (timed_out) begin
            state_n = FINISH;
            set_to  = 1'b1;
          end else if (mem_rdata_i == 32'd1) begin
            state_n = FINISH;
          end else begin
            state_n = POLL_WAIT;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// tb_kernel_launch_ctrl: table of launch scenarios against a bus
// model with a transaction scoreboard, plus a reset-in-poll sequence.
module tb_kernel_launch_ctrl;

  localparam int SETTLE = 50;
  localparam int POLL   = 16;
  localparam int TMO    = 200;
  localparam logic [31:0] DADDR = 32'h0002_7C00;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        launch_i = 1'b0;
  logic        busy_o, done_o, timeout_o;
  logic [31:0] cycles_o;
  logic        conf_req_o, conf_we_o;
  logic        conf_gnt_i = 1'b0;
  logic        conf_rvalid_i = 1'b0;
  logic [3:0]  conf_be_o;
  logic [31:0] conf_addr_o, conf_wdata_o;
  logic        mem_req_o, mem_we_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  kernel_launch_ctrl #(
    .RST_REG_ADDR  (32'h0),
    .START_REG_ADDR(32'h4),
    .DONE_ADDR     (DADDR),
    .SETTLE_CYCLES (SETTLE),
    .POLL_INTERVAL (POLL),
    .TIMEOUT_CYCLES(32'(TMO))
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .launch_i     (launch_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .cycles_o     (cycles_o),
    .conf_req_o   (conf_req_o),
    .conf_gnt_i   (conf_gnt_i),
    .conf_we_o    (conf_we_o),
    .conf_be_o    (conf_be_o),
    .conf_addr_o  (conf_addr_o),
    .conf_wdata_o (conf_wdata_o),
    .conf_rvalid_i(conf_rvalid_i),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    string name;
    int    stall;
    int    done_poll;
    bit    relaunch;
    bit    exp_to;
    int    exp_polls;
  } case_t;

  txn_t  exp_q[$];
  case_t cases[5];

  int total = 0;
  int bad = 0;
  int edge_no = 0;
  int c_stall = 0;
  int done_poll = 0;
  int polls = 0;
  int done_cnt = 0;
  int g_rst = 0;
  int g_start = 0;
  int r_edge = 0;
  int start_edge = 0;
  bit start_seen = 0;
  bit mem_hold = 0;
  bit stray = 0;
  bit conf_pend = 0;
  bit mem_pend = 0;
  bit prev_stall = 0;
  logic [31:0] mem_pend_data = '0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(bit m, logic [31:0] a,
                              logic [31:0] d);
    txn_t t;
    t.is_mem = m;
    t.addr   = a;
    t.wdata  = d;
    return t;
  endfunction

  task automatic sb_check(bit m, logic [31:0] a,
                          logic [31:0] d, logic we,
                          logic [3:0] be);
    txn_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_txn: got addr %0h want none", a);
    end else begin
      e = exp_q.pop_front();
      chk("txn_kind", 32'(m), 32'(e.is_mem));
      chk("txn_addr", a, e.addr);
      if (!e.is_mem) chk("txn_wdata", d, e.wdata);
      chk("txn_we", 32'(we), 32'(!e.is_mem));
      chk("txn_be", 32'(be), 32'hF);
    end
  endtask

  always @(posedge clk) edge_no <= edge_no + 1;

  // Bus model: grants (optionally stalled), returns rvalid one
  // cycle after each grant, and scores every accepted request.
  always @(negedge clk) begin
    conf_rvalid_i = conf_pend;
    mem_rvalid_i  = mem_pend;
    mem_rdata_i   = mem_pend ? mem_pend_data : 32'h0;
    if (mem_pend) r_edge = edge_no + 1;
    conf_pend = 0;
    mem_pend  = 0;
    if (stray) begin
      conf_rvalid_i = 1'b1;
      mem_rvalid_i  = 1'b1;
      mem_rdata_i   = 32'd1;
      stray = 0;
    end
    if (prev_stall) begin
      chk("hold_req", 32'(conf_req_o), 32'd1);
      chk("hold_addr", conf_addr_o, prev_addr);
      chk("hold_wdata", conf_wdata_o, prev_wdata);
    end
    if (conf_req_o) chk("req_excl", 32'(mem_req_o), 32'd0);
    if (mem_req_o) chk("mem_we", 32'(mem_we_o), 32'd0);
    conf_gnt_i = 1'b0;
    mem_gnt_i  = 1'b0;
    if (rst_ni && conf_req_o) begin
      if (c_stall > 0) c_stall--;
      else conf_gnt_i = 1'b1;
    end
    if (rst_ni && mem_req_o && !mem_hold) mem_gnt_i = 1'b1;
    prev_stall = rst_ni && conf_req_o && !conf_gnt_i;
    prev_addr  = conf_addr_o;
    prev_wdata = conf_wdata_o;
    if (conf_req_o && !start_seen && conf_addr_o == 32'h4) begin
      start_seen = 1;
      start_edge = edge_no;
    end
    if (conf_req_o && conf_gnt_i) begin
      conf_pend = 1;
      if (conf_addr_o == 32'h0) g_rst = edge_no + 1;
      else g_start = edge_no + 1;
      sb_check(0, conf_addr_o, conf_wdata_o, conf_we_o,
               conf_be_o);
    end
    if (mem_req_o && mem_gnt_i) begin
      mem_pend = 1;
      polls++;
      mem_pend_data = (polls == done_poll) ? 32'd1 : 32'd0;
      sb_check(1, mem_addr_o, 32'h0, mem_we_o, mem_be_o);
    end
    if (done_o) done_cnt++;
  end

  task automatic run_case(case_t c);
    int n;
    logic [31:0] cyc;
    exp_q.delete();
    c_stall    = c.stall;
    done_poll  = c.done_poll;
    polls      = 0;
    done_cnt   = 0;
    start_seen = 0;
    exp_q.push_back(mk(0, 32'h0, 32'd1));
    exp_q.push_back(mk(0, 32'h4, 32'd1));
    for (int k = 0; k < c.exp_polls; k++)
      exp_q.push_back(mk(1, DADDR, 32'd0));
    launch_i = 1'b1;
    @(negedge clk);
    launch_i = 1'b0;
    chk({c.name, "_busy"}, 32'(busy_o), 32'd1);
    chk({c.name, "_to_clr"}, 32'(timeout_o), 32'd0);
    if (c.relaunch) begin
      repeat (20) @(negedge clk);
      launch_i = 1'b1;
      @(negedge clk);
      launch_i = 1'b0;
    end
    n = 0;
    while (!done_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({c.name, "_done"}, 32'(done_o), 32'd1);
    chk({c.name, "_timeout"}, 32'(timeout_o), 32'(c.exp_to));
    if (c.exp_to)
      chk({c.name, "_cyc_ge"}, 32'(cycles_o >= 32'(TMO)), 32'd1);
    else
      chk({c.name, "_cycles"}, cycles_o, 32'(r_edge - g_start));
    cyc = cycles_o;
    @(negedge clk);
    chk({c.name, "_idle"}, 32'(busy_o), 32'd0);
    chk({c.name, "_pulse"}, 32'(done_o), 32'd0);
    repeat (40) @(negedge clk);
    chk({c.name, "_polls"}, 32'(polls), 32'(c.exp_polls));
    chk({c.name, "_ndone"}, 32'(done_cnt), 32'd1);
    chk({c.name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({c.name, "_settle"}, 32'(start_edge - g_rst),
        32'(SETTLE + 1));
    chk({c.name, "_cyc_hold"}, cycles_o, cyc);
    chk({c.name, "_to_hold"}, 32'(timeout_o), 32'(c.exp_to));
  endtask

  task automatic reset_seq();
    int n;
    exp_q.delete();
    c_stall    = 0;
    done_poll  = 0;
    polls      = 0;
    done_cnt   = 0;
    start_seen = 0;
    mem_hold   = 1;
    exp_q.push_back(mk(0, 32'h0, 32'd1));
    exp_q.push_back(mk(0, 32'h4, 32'd1));
    launch_i = 1'b1;
    @(negedge clk);
    launch_i = 1'b0;
    n = 0;
    while (!mem_req_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rq_mem_req", 32'(mem_req_o), 32'd1);
    @(negedge clk);
    chk("rq_held", 32'(mem_req_o), 32'd1);
    chk("rq_addr", mem_addr_o, DADDR);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("rq_req_drop", 32'(mem_req_o), 32'd0);
    chk("rq_busy", 32'(busy_o), 32'd0);
    chk("rq_maddr", mem_addr_o, 32'h0);
    chk("rq_cycles", cycles_o, 32'h0);
    rst_ni   = 1'b1;
    mem_hold = 0;
    stray    = 1;
    repeat (3) @(negedge clk);
    chk("rq_stray_busy", 32'(busy_o), 32'd0);
    chk("rq_stray_done", 32'(done_cnt), 32'd0);
    chk("rq_polls", 32'(polls), 32'd0);
    chk("rq_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    cases[0] = '{"nominal",     0, 3, 1'b0, 1'b0, 3};
    cases[1] = '{"grant_stall", 5, 1, 1'b0, 1'b0, 1};
    cases[2] = '{"relaunch",    0, 2, 1'b1, 1'b0, 2};
    cases[3] = '{"timeout",     0, 0, 1'b0, 1'b1, 11};
    cases[4] = '{"poll1",       0, 1, 1'b0, 1'b0, 1};

    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_conf_req", 32'(conf_req_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_cycles", cycles_o, 32'h0);
    chk("rst_conf_addr", conf_addr_o, 32'h0);
    chk("rst_conf_wdata", conf_wdata_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_case(cases[i]);
    reset_seq();
    run_case(cases[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
